counter_stim_gen: RTL

//  Synthesizable, parametrised stimulus generator for the mode counter. Drives enable,
//  DUT reset, mode and D in a directed sweep, then a pseudo-random phase. Same port

---
 rtl/counter_stim_gen_pkg.sv | 34 +++
 rtl/counter_stim_gen_lfsr16.sv | 20 ++
 rtl/counter_stim_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/counter_stim_gen_pkg.sv
// Shared codes for the mode-counter stimulus generator: counter mode codes,
// enable levels, phase codes and LFSR constants.
package counter_stim_gen_pkg;

    // Counter mode codes
    localparam logic [1:0] CUENTA_TRES_TRES = 2'b00;
    localparam logic [1:0] CUENTA_MENOS_UNO = 2'b01;
    localparam logic [1:0] CUENTA_MAS_UNO   = 2'b10;
    localparam logic [1:0] CARGA_D          = 2'b11;

    localparam logic ACTIVO      = 1'b1;
    localparam logic DESACTIVADO = 1'b0;

    // Galois feedback mask and the fallback seed used when a zero seed is given
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // State encoding doubles as the phase code seen on the phase port
    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_INIT = 3'd1,
        PH_M00  = 3'd2,
        PH_M01  = 3'd3,
        PH_M10  = 3'd4,
        PH_M11  = 3'd5,
        PH_RAND = 3'd6
    } state_t;

    // One Galois step; the mask keeps a nonzero register nonzero
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/counter_stim_gen_lfsr16.sv
// 16-bit Galois LFSR; loads the seed on reset, advances only while enabled.
module stim_lfsr16
    import counter_stim_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Shift register: seed on reset, one Galois step per enabled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= seed;
        else if (en)
            q <= lfsr_step(q);
    end

endmodule

// File: rtl/counter_stim_gen.sv
// Clocked stimulus generator for the mode counter: INIT, directed sweep of the
// four modes, then pseudo-random phases, optionally ending with a done pulse.
module counter_stim_gen
    import counter_stim_gen_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          PHASE_LEN   = 35,
    parameter int          D_PERIOD    = 10,
    parameter int          RAND_PHASES = 0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             enable,
    output logic             dut_reset,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] D,
    output logic [2:0]       phase,
    output logic             done
);

    localparam int CW = $clog2(PHASE_LEN);
    localparam int DW = (D_PERIOD > 1) ? $clog2(D_PERIOD) : 1;

    localparam logic [CW-1:0] PL_LAST  = CW'(PHASE_LEN - 1);
    localparam logic [CW-1:0] PL_PEN   = CW'(PHASE_LEN - 2);
    localparam logic [CW-1:0] PL_THIRD = CW'(PHASE_LEN / 3);
    localparam logic [CW-1:0] PL_2THRD = CW'((2 * PHASE_LEN) / 3);
    localparam logic [DW-1:0] DP_LAST  = DW'(D_PERIOD - 1);
    localparam logic [15:0]   RP_LAST  = 16'(RAND_PHASES - 1);
    localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT : SEED;

    state_t            state, state_n;
    logic [CW-1:0]     cyc, cyc_n;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [15:0]       rcnt, rcnt_n;
    logic              enable_n, dut_reset_n, done_n;
    logic [1:0]        mode_n;
    logic [WIDTH-1:0]  d_n;
    logic [15:0]       lfsr_q;
    logic              cyc_last, run_last;
    logic              unused_lfsr_bits;

    stim_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state != PH_IDLE),
        .seed  (SEED_EFF),
        .q     (lfsr_q)
    );

    // Not every LFSR bit feeds an output at narrow WIDTH
    assign unused_lfsr_bits = ^lfsr_q;

    assign phase = state;

    // State, counters and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PH_IDLE;
            cyc       <= '0;
            dcnt      <= '0;
            rcnt      <= '0;
            enable    <= DESACTIVADO;
            dut_reset <= ACTIVO;
            mode      <= CARGA_D;
            D         <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            dcnt      <= dcnt_n;
            rcnt      <= rcnt_n;
            enable    <= enable_n;
            dut_reset <= dut_reset_n;
            mode      <= mode_n;
            D         <= d_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        cyc_n       = cyc;
        dcnt_n      = dcnt;
        rcnt_n      = rcnt;
        enable_n    = enable;
        dut_reset_n = dut_reset;
        mode_n      = mode;
        d_n         = D;
        done_n      = 1'b0;
        cyc_last    = (cyc == PL_LAST);
        run_last    = (RAND_PHASES != 0) && (rcnt == RP_LAST);

        // D cadence runs in every active state, independent of the phase counter
        if (state != PH_IDLE) begin
            if (dcnt == DP_LAST) begin
                dcnt_n = '0;
                d_n    = lfsr_q[WIDTH-1:0];
            end else begin
                dcnt_n = dcnt + 1'b1;
            end
        end

        case (state)
            PH_IDLE: begin
                if (start) begin
                    state_n     = PH_INIT;
                    cyc_n       = '0;
                    dcnt_n      = '0;
                    rcnt_n      = '0;
                    enable_n    = DESACTIVADO;
                    dut_reset_n = ACTIVO;
                    mode_n      = CARGA_D;
                    d_n         = '0;
                end
            end
            PH_INIT: begin
                state_n     = PH_M00;
                cyc_n       = '0;
                enable_n    = ACTIVO;
                dut_reset_n = DESACTIVADO;
                mode_n      = CUENTA_TRES_TRES;
            end
            PH_M00, PH_M01, PH_M10, PH_M11: begin
                if (cyc_last) begin
                    cyc_n   = '0;
                    state_n = state_t'(state + 3'd1);
                    // M11 hands over to RAND still showing 11
                    if (state != PH_M11)
                        mode_n = mode + 2'd1;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            PH_RAND: begin
                cyc_n = cyc_last ? '0 : cyc + 1'b1;
                if (cyc == '0)
                    mode_n = lfsr_q[1:0];
                if (cyc == PL_THIRD)
                    enable_n = lfsr_q[2];
                if (cyc == PL_2THRD)
                    dut_reset_n = lfsr_q[3] & lfsr_q[4];
                // Registered one cycle ahead so done is high on the last cycle
                if (cyc == PL_PEN && run_last)
                    done_n = 1'b1;
                if (cyc_last) begin
                    rcnt_n = rcnt + 16'd1;
                    if (run_last) begin
                        state_n     = PH_IDLE;
                        enable_n    = DESACTIVADO;
                        dut_reset_n = DESACTIVADO;
                        mode_n      = mode;
                        d_n         = D;
                    end
                end
            end
            default: state_n = PH_IDLE;
        endcase
    end

endmodule
